lseq_counter: RTL

//  Step sequencer feeding the 6-position one-hot lamp decoder.

---
 rtl/lseq_pkg.sv | 9 +
 rtl/lseq_prescaler.sv | 30 +++
 rtl/lseq_counter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/lseq_pkg.sv
// Shared types and constants for the lamp step sequencer.
package lseq_pkg;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] IDLE_CODE = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} lseq_state_t;

endpackage

// File: rtl/lseq_prescaler.sv
// Free-running divider that pulses step once every CLK_DIV enabled cycles.
module lseq_prescaler #(
  parameter int CLK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] TOP = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == TOP) ? '0 : cnt_q + W'(1);
    end
  end

  // A clear in the same cycle suppresses the pulse so a restart never steps.
  assign step = en && !clr && (cnt_q == TOP);

endmodule

// File: rtl/lseq_counter.sv
// Step sequencer driving the one-hot lamp decoder; emits IDLE_CODE when stopped.
// Define LSEQ_BOUNCE_EN for ping-pong traversal instead of wrap-around.
module lseq_counter
  import lseq_pkg::*;
#(
  parameter int CLK_DIV   = 25_000_000,
  parameter int NUM_STEPS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             dir,
  output logic [CNT_W-1:0] now_count,
  output logic             running,
  output logic             tick,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_STEPS - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  lseq_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             running_q, running_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             step, presc_clr, presc_en;
`ifdef LSEQ_BOUNCE_EN
  logic             down_q, down_d;
`endif

  // Prescaler only advances in RUN with hold low, so no step can land in HOLD.
  assign presc_clr = (state_q == S_IDLE) || start || stop;
  assign presc_en  = (state_q == S_RUN) && !hold;

  lseq_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (presc_clr),
    .en   (presc_en),
    .step (step)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
`ifdef LSEQ_BOUNCE_EN
    down_d  = down_q;
`endif
    if (stop) begin
      state_d = S_IDLE;
      count_d = IDLE_CODE;
    end else if (start) begin
      state_d = S_RUN;
      count_d = dir ? LAST : '0;
`ifdef LSEQ_BOUNCE_EN
      down_d  = dir;
`endif
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (hold) begin
            state_d = S_HOLD;
          end else if (step) begin
            tick_d = 1'b1;
`ifdef LSEQ_BOUNCE_EN
            if (!down_q) begin
              if (count_q == LAST) begin
                count_d = count_q - ONE;
                down_d  = 1'b1;
                wrap_d  = 1'b1;
              end else begin
                count_d = count_q + ONE;
              end
            end else begin
              if (count_q == '0) begin
                count_d = ONE;
                down_d  = 1'b0;
                wrap_d  = 1'b1;
              end else begin
                count_d = count_q - ONE;
              end
            end
`else
            if (!dir) begin
              wrap_d  = (count_q == LAST);
              count_d = (count_q == LAST) ? '0 : count_q + ONE;
            end else begin
              wrap_d  = (count_q == '0);
              count_d = (count_q == '0) ? LAST : count_q - ONE;
            end
`endif
          end
        end
        S_HOLD: begin
          if (!hold) state_d = S_RUN;
        end
        default: begin
        end
      endcase
    end
    running_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= IDLE_CODE;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
`ifdef LSEQ_BOUNCE_EN
      down_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      running_q <= running_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
`ifdef LSEQ_BOUNCE_EN
      down_q    <= down_d;
`endif
    end
  end

  assign now_count = count_q;
  assign running   = running_q;
  assign tick      = tick_q;
  assign wrap      = wrap_q;

endmodule
